// File: rtl/next_kms_pkg.sv
// next_kms_pkg: constants shared by the NeXT KMS serial-link sender and receiver,
// plus the receiver FSM state type.
package next_kms_pkg;
    localparam int PKT_W   = 40;
    localparam int FRAME_W = 41;
    localparam logic [PKT_W-1:0] AUDIO_REQ_PKT = 40'h07_0000_0000;
    localparam logic [PKT_W-1:0] UNDERRUN_PKT  = 40'h0F_0000_0000;
    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_GAP} rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= 2'b00;
        else sync_q <= {sync_q[0], d};
    assign q = sync_q[1];
endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: NeXT KMS serial-to-parallel receiver (start bit + 40 bits MSB first)
// with a one-word holding register; define PACKET_RECEIVER_SYNC_EN to synchronize sin.
module packet_receiver
    import next_kms_pkg::*;
#(
    parameter int GAP_MIN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_audio_req,
    output logic             is_underrun,
    output logic             overrun,
    output logic             gap_error,
    output logic             busy
);
    localparam int GW = 16;
    logic s;
`ifdef PACKET_RECEIVER_SYNC_EN
    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(sin), .q(s));
`else
    assign s = sin;
`endif
    rx_state_e        state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [PKT_W-1:0] shreg_q, shreg_d, data_q, data_d, word;
    logic             valid_q, valid_d, ovr_q, ovr_d, gerr_q, gerr_d, push;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        gerr_d  = 1'b0;
        push    = 1'b0;
        word    = {shreg_q[PKT_W-2:0], s};
        case (state_q)
            RX_IDLE: if (s) begin
                state_d = RX_SHIFT;
                cnt_d   = '0;
            end
            RX_SHIFT: begin
                shreg_d = word;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(PKT_W - 1)) begin
                    push    = 1'b1;
                    state_d = RX_GAP;
                    gap_d   = '0;
                end
            end
            RX_GAP: if (s) begin
                // an early start bit is still honoured so the packet is not lost
                gerr_d  = 1'b1;
                state_d = RX_SHIFT;
                cnt_d   = '0;
            end else begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_MIN - 1)) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        ovr_d   = push & valid_q & ~out_ready;
        if (push & ~ovr_d) begin
            data_d  = word;
            valid_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            gerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            gerr_q  <= gerr_d;
        end
    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign overrun      = ovr_q;
    assign gap_error    = gerr_q;
    assign busy         = state_q != RX_IDLE;
    assign is_audio_req = data_q == AUDIO_REQ_PKT;
    assign is_underrun  = data_q == UNDERRUN_PKT;
endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: drives two receivers (GAP_MIN=1 and GAP_MIN=3) from one serial line
// and checks delivered words, flags and pulses against a one-slot buffer model.
module tb_packet_receiver;
    logic        clk = 1'b0, rst_n = 1'b0, sin = 1'b0, out_ready = 1'b0;
    logic [39:0] d1, d3;
    logic        v1, v3, a1, a3, u1, u3, o1, o3, g1, g3, b1, b3;
    always #5 clk = ~clk;
    packet_receiver #(.GAP_MIN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sin(sin), .out_data(d1), .out_valid(v1), .out_ready(out_ready),
        .is_audio_req(a1), .is_underrun(u1), .overrun(o1), .gap_error(g1), .busy(b1));
    packet_receiver #(.GAP_MIN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sin(sin), .out_data(d3), .out_valid(v3), .out_ready(out_ready),
        .is_audio_req(a3), .is_underrun(u3), .overrun(o3), .gap_error(g3), .busy(b3));
    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [39:0] r1_q[$], r3_q[$], exp_q[$];
    logic [1:0]  c1_q[$];
    int          hs_cyc[$];
    int          ov1, ov3, ge1, ge3, vcnt1;
    always @(negedge clk) if (rst_n) begin
        if (v1 && out_ready) begin
            r1_q.push_back(d1);
            c1_q.push_back({a1, u1});
            hs_cyc.push_back(cyc);
        end
        if (v3 && out_ready) r3_q.push_back(d3);
        ov1 += int'(o1);
        ov3 += int'(o3);
        ge1 += int'(g1);
        ge3 += int'(g3);
        vcnt1 += int'(v1);
    end
    int          rdy_mode, exp_ov, last_start;
    logic        m_full;
    logic [39:0] m_word;
    task automatic clear();
        r1_q.delete(); r3_q.delete(); c1_q.delete(); hs_cyc.delete(); exp_q.delete();
        ov1 = 0; ov3 = 0; ge1 = 0; ge3 = 0; vcnt1 = 0; exp_ov = 0; m_full = 1'b0;
    endtask
    task automatic drive_bit(input logic b, input logic push, input logic [39:0] w);
        logic r;
        r = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : rdy_mode == 3 ? push :
            ($urandom_range(0, 31) == 0);
        sin = b;
        out_ready = r;
        if (push && m_full && !r) exp_ov++;
        else begin
            if (m_full && r) exp_q.push_back(m_word);
            if (push) begin
                m_word = w;
                m_full = 1'b1;
            end else if (r) m_full = 1'b0;
        end
        @(posedge clk); #1;
    endtask
    task automatic send(input logic [39:0] w, input int gap);
        for (int i = 0; i < gap; i++) drive_bit(1'b0, 1'b0, '0);
        last_start = cyc;
        drive_bit(1'b1, 1'b0, '0);
        for (int i = 39; i >= 0; i--) drive_bit(w[i], i == 0, w);
    endtask
    task automatic drain();
        rdy_mode = 0;
        repeat (6) drive_bit(1'b0, 1'b0, '0);
    endtask
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({v1, b1, o1, g1, v3, b3, o3, g3} !== 8'h00) begin
            bad++; $display("FAIL reset_flags: got %b want 00000000", {v1, b1, o1, g1, v3, b3, o3, g3});
        end
        total++;
        if (d1 !== 40'h0 || d3 !== 40'h0) begin
            bad++; $display("FAIL reset_data: got %h/%h want 0", d1, d3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_basic();
        logic [39:0] w;
        int t;
        w = 40'hA5_1234_5678;
        clear();
        rdy_mode = 0;
        send(w, 3);
        t = last_start;
        drain();
        total++;
        if (r1_q.size() != 1 || vcnt1 != 1) begin
            bad++; $display("FAIL basic_count: got words=%0d valid_cycles=%0d want 1/1", r1_q.size(), vcnt1);
        end else begin
            total++;
            if (r1_q[0] !== w) begin bad++; $display("FAIL basic_word: got %h want %h", r1_q[0], w); end
            total++;
            if (hs_cyc[0] != t + 41) begin
                bad++; $display("FAIL basic_latency: got cycle %0d want %0d", hs_cyc[0], t + 41);
            end
        end
        total++;
        if (ov1 + ge1 + ov3 + ge3 != 0) begin
            bad++; $display("FAIL basic_pulses: got %0d error pulses want 0", ov1 + ge1 + ov3 + ge3);
        end
    endtask
    task automatic test_audio();
        clear();
        rdy_mode = 0;
        send(40'h07_0000_0000, 3);
        send(40'h0F_0000_0000, 1);
        drain();
        total++;
        if (r1_q.size() != 2 || r3_q.size() != 2) begin
            bad++; $display("FAIL audio_count: got %0d/%0d want 2/2", r1_q.size(), r3_q.size());
        end else begin
            total++;
            if (c1_q[0] !== 2'b10 || c1_q[1] !== 2'b01) begin
                bad++; $display("FAIL audio_flags: got %b,%b want 10,01", c1_q[0], c1_q[1]);
            end
            total++;
            if (r3_q[1] !== 40'h0F_0000_0000) begin
                bad++; $display("FAIL audio_gap3_word: got %h want 0f00000000", r3_q[1]);
            end
        end
        total++;
        if (ge1 != 0 || ge3 != 1) begin
            bad++; $display("FAIL audio_gap_err: got %0d/%0d want 0/1", ge1, ge3);
        end
    endtask
    task automatic test_overrun();
        clear();
        rdy_mode = 1;
        send(40'h1, 3);
        send(40'h2, 3);
        repeat (4) drive_bit(1'b0, 1'b0, '0);
        @(negedge clk);
        total++;
        if (v1 !== 1'b1 || d1 !== 40'h1) begin
            bad++; $display("FAIL ovr_hold: got v=%b %h want v=1 0000000001", v1, d1);
        end
        total++;
        if (ov1 != 1 || ov3 != 1 || exp_ov != 1) begin
            bad++; $display("FAIL ovr_pulse: got %0d/%0d want 1", ov1, ov3);
        end
        drain();
        total++;
        if (r1_q.size() != 1 || r1_q[0] !== 40'h1) begin
            bad++; $display("FAIL ovr_drop: got %0d words want single 0000000001", r1_q.size());
        end
    endtask
    task automatic test_ready_on_push();
        clear();
        rdy_mode = 3;
        send(40'h1, 3);
        send(40'h2, 3);
        drain();
        total++;
        if (r1_q.size() != 2 || r1_q[0] !== 40'h1 || r1_q[1] !== 40'h2) begin
            bad++; $display("FAIL rop_words: got %0d words want 0000000001,0000000002", r1_q.size());
        end
        total++;
        if (ov1 != 0 || exp_ov != 0) begin bad++; $display("FAIL rop_overrun: got %0d want 0", ov1); end
    endtask
    task automatic test_gap_error();
        logic [39:0] wa, wb;
        wa = {8'($urandom), 32'($urandom)};
        wb = {8'($urandom), 32'($urandom)};
        clear();
        rdy_mode = 0;
        send(wa, 3);
        send(wb, 0);
        drain();
        total++;
        if (ge1 != 1 || ge3 != 1) begin bad++; $display("FAIL gap_pulse: got %0d/%0d want 1/1", ge1, ge3); end
        total++;
        if (r3_q.size() != 2 || r3_q[0] !== wa || r3_q[1] !== wb) begin
            bad++; $display("FAIL gap_words: got %0d words want %h,%h", r3_q.size(), wa, wb);
        end
    endtask
    task automatic test_reset_mid();
        logic [39:0] w;
        w = 40'h5A_C3C3_9696;
        clear();
        rdy_mode = 0;
        repeat (3) drive_bit(1'b0, 1'b0, '0);
        drive_bit(1'b1, 1'b0, '0);
        for (int i = 39; i >= 20; i--) drive_bit(w[i], 1'b0, '0);
        #2 rst_n = 1'b0;
        sin = 1'b0;
        #1;
        total++;
        if ({b1, b3, v1, v3} !== 4'b0000) begin
            bad++; $display("FAIL rstmid_abort: got %b want 0000", {b1, b3, v1, v3});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(40'hFF_FFFF_FFFF, 2);
        drain();
        total++;
        if (r1_q.size() != 1 || r1_q[0] !== 40'hFF_FFFF_FFFF || r3_q.size() != 1) begin
            bad++; $display("FAIL rstmid_word: got %0d words want single ffffffffff", r1_q.size());
        end
    endtask
    task automatic test_random();
        int gap, exp_ge3;
        logic [39:0] w;
        clear();
        exp_ge3 = 0;
        rdy_mode = 2;
        for (int i = 0; i < 14; i++) begin
            w = (i % 5 == 1) ? 40'h07_0000_0000 : (i % 5 == 3) ? 40'h0F_0000_0000 :
                {8'($urandom), 32'($urandom)};
            gap = (i == 0) ? 3 : $urandom_range(1, 5);
            if (i > 0 && gap < 3) exp_ge3++;
            send(w, gap);
        end
        drain();
        total++;
        if (r1_q.size() != exp_q.size() || r3_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d/%0d want %0d", r1_q.size(), r3_q.size(), exp_q.size());
        end else
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (r1_q[i] !== exp_q[i] || r3_q[i] !== exp_q[i] ||
                    c1_q[i] !== {exp_q[i] == 40'h07_0000_0000, exp_q[i] == 40'h0F_0000_0000}) begin
                    bad++; $display("FAIL rand_word%0d: got %h/%h flags %b want %h", i, r1_q[i], r3_q[i], c1_q[i], exp_q[i]);
                end
            end
        total++;
        if (ov1 != exp_ov || ov3 != exp_ov) begin
            bad++; $display("FAIL rand_overrun: got %0d/%0d want %0d", ov1, ov3, exp_ov);
        end
        total++;
        if (ge1 != 0 || ge3 != exp_ge3) begin
            bad++; $display("FAIL rand_gap: got %0d/%0d want 0/%0d", ge1, ge3, exp_ge3);
        end
    endtask
    initial begin
        clear();
        rdy_mode = 0;
        test_reset();
        test_basic();
        test_audio();
        test_overrun();
        test_ready_on_push();
        test_gap_error();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
